// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl -- multi-cycle multiply/divide unit with HI/LO registers.
//
// mult/multu/div/divu compute their result when issued, then hold the unit
// busy for MULT_CYCLES or DIV_CYCLES cycles. The HI/LO commit happens on the
// last busy cycle. mthi/mtlo write HI/LO directly at the next edge.
//
// Build option:
//   MULDIV_CANCEL_EN  adds the Cancel input, which aborts an in-flight
//                     operation with no commit.
//
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous active-high reset
//   Start   in   1   E-stage request to issue MDOp
//   MDOp    in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi,
//                    101 mtlo, 11x no-op
//   A, B    in   32  forwarded RS / RT operands
//   D_IsMD  in   1   D stage holds a mult/div/mfhi/mflo/mthi/mtlo
//   Cancel  in   1   abort the in-flight operation (MULDIV_CANCEL_EN only)
//   HI, LO  out  32  architectural HI / LO registers
//   Busy    out  1   multi-cycle operation in flight
//   Stall   out  1   D-stage stall request
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_IsMD,
`ifdef MULDIV_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        res_q, res_d;   // pending {HI, LO} value
    logic               dz_q, dz_d;     // pending divide had B == 0
    logic               cancel_w;

`ifdef MULDIV_CANCEL_EN
    assign cancel_w = Cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Extending both operands to 64 bits (sign or zero) makes the low 64 bits
    // of the product correct for both signed and unsigned multiply.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the sign of the dividend. 0x80000000 / -1 falls out
    // as quotient 0x80000000, remainder 0. A zero divisor is replaced by 1
    // only to keep the result defined; that result is never committed.
    // Returns {remainder, quotient}.
    function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg_q;
        logic        neg_r;
        neg_q = is_signed & (a[31] ^ b[31]);
        neg_r = is_signed & a[31];
        ua    = (is_signed && a[31]) ? -a : a;
        ub    = (is_signed && b[31]) ? -b : b;
        if (ub == 32'd0) begin
            ub = 32'd1;
        end
        q = ua / ub;
        r = ua % ub;
        if (neg_q) begin
            q = -q;
        end
        if (neg_r) begin
            r = -r;
        end
        return {r, q};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            res_d   = mul64(A, B, MDOp == OP_MULT);
                            dz_d    = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_MULT;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_d   = divide(A, B, MDOp == OP_DIV);
                            dz_d    = (B == 32'd0);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MULT, S_DIV: begin
                // Start is ignored here; Cancel outranks the commit.
                if (cancel_w) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The pending result is only read while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        res_q <= res_d;
        dz_q  <= dz_d;
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = (state_q != S_IDLE);
    // MDOp[2] == 0 selects mult/multu/div/divu.
    assign Stall = D_IsMD & (Busy | (Start & ~MDOp[2]));

endmodule
